// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debouncing and registered key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 13500000,
    parameter int unsigned REPEAT_PERIOD   = 4050000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_n,
    output logic       keypad_pressed,
    output logic [4:0] key,
    output logic       key_held
);

    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    // The HELD cycle that first sees all-high counts toward the release window.
    localparam logic [DW-1:0] REL_LAST  = DW'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      col_q1;
    logic [3:0]      col_s;
    logic [1:0]      row_idx;
    logic [3:0]      pattern;
    logic [1:0]      cap_col;
    logic            cap_multi;
    logic [SW-1:0]   scan_cnt;
    logic [DW-1:0]   db_cnt;
    logic [3:0]      col_low;
    logic [1:0]      low_col;
    logic            low_found;
    logic            multi_now;
    logic            capture;
    logic            rotate;
    logic            accept;
    logic            release_done;
    logic            rep_fire;

    assign row_n     = ~(4'b0001 << row_idx);
    assign col_low   = ~col_s;
    assign multi_now = |(col_low & (col_low - 4'd1));

    always_comb begin
        low_col   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (col_low[i] && !low_found) begin
                low_col   = 2'(i);
                low_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        rotate       = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    if (col_s != 4'hF) begin
                        state_nxt = DEBOUNCE;
                        capture   = 1'b1;
                    end else begin
                        rotate = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (col_s != pattern) begin
                    state_nxt = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = HELD;
                    accept    = 1'b1;
                end
            end
            HELD: begin
                if (col_s == 4'hF) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_nxt    = SCAN;
                        release_done = 1'b1;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (col_s != 4'hF) begin
                    state_nxt = HELD;
                end else if (db_cnt == REL_LAST) begin
                    state_nxt    = SCAN;
                    release_done = 1'b1;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer idles at the pulled-up level so reset never looks like a press.
            col_q1         <= '1;
            col_s          <= '1;
            row_idx        <= '0;
            pattern        <= '1;
            cap_col        <= '0;
            cap_multi      <= 1'b0;
            scan_cnt       <= '0;
            db_cnt         <= '0;
            keypad_pressed <= 1'b0;
            key            <= '0;
            key_held       <= 1'b0;
        end else begin
            col_q1 <= col_in;
            col_s  <= col_q1;

            if (state_nxt != state || state != SCAN || rotate) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            if (state_nxt != state || (state != DEBOUNCE && state != RELEASE)) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            if (capture) begin
                pattern   <= col_s;
                cap_col   <= low_col;
                cap_multi <= multi_now;
            end

            if (rotate || release_done) begin
                row_idx <= row_idx + 2'd1;
            end

            keypad_pressed <= accept || rep_fire;
            if (accept) begin
                key      <= {cap_multi, row_idx, cap_col};
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_active;

    // Counting spans release bounces: only a fresh accept restarts the repeat timeline.
    assign rep_active = (state == HELD) && (col_s != 4'hF);
    assign rep_fire   = rep_active && (rep_armed ? (rep_cnt == PERIOD_LAST) : (rep_cnt == DELAY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (accept) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else if (rep_active) begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized scoreboard bench for keypad_scan_ctrl; build with KEYPAD_REPEAT_EN to cover auto-repeat.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN    = 4;
    localparam int unsigned DB      = 8;
    localparam int unsigned LAT_MAX = 4 * SCAN + DB + 3;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_n;
    logic       keypad_pressed;
    logic [4:0] key;
    logic       key_held;

    // Keypad model: the pressed key's columns read low only while its row is driven.
    logic       k_down = 1'b0;
    logic [1:0] k_row  = '0;
    logic [3:0] k_mask = '0;
    assign col_in = (k_down && row_n == ~(4'b0001 << k_row)) ? ~k_mask : 4'hF;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned acc_cyc  = 0;

    typedef struct {
        logic [4:0]  code;
        int unsigned offset;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(SCAN),
        .DEBOUNCE_CYCLES(DB)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_in(col_in),
        .row_n(row_n),
        .keypad_pressed(keypad_pressed),
        .key(key),
        .key_held(key_held)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [4:0] key_code(input int unsigned row, input logic [3:0] mask);
        int unsigned n = 0;
        int unsigned lowest = 4;
        for (int unsigned c = 0; c < 4; c++) begin
            if (mask[c]) begin
                n++;
                if (lowest == 4) lowest = c;
            end
        end
        return {(n > 1) ? 1'b1 : 1'b0, 2'(row), 2'(lowest)};
    endfunction

    function automatic logic [3:0] row_pat(input int unsigned idx);
        return ~(4'b0001 << (idx % 4));
    endfunction

    function automatic int unsigned pick_hold();
        int unsigned h;
        bit ok;
        do begin
            h  = $urandom_range(24, 60);
            ok = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            for (int unsigned o = RD; o <= h + 3; o += RP) if (o + 1 >= h) ok = 1'b0;
`endif
        end while (!ok);
        return h;
    endfunction

    // Monitor: every strobe must match the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            check("row_one_low", $countones(~row_n), 1);
            if (rst_n && keypad_pressed) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe key=%b expected no strobe at %0t", key, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_key", key, e.code);
                    check("strobe_key_held", key_held, 1);
                    if (e.offset == 0) acc_cyc = cyc;
                    else check("repeat_offset", cyc - acc_cyc, e.offset);
                end
            end
        end
    end

    task automatic wait_accept(output bit seen);
        seen = 1'b0;
        for (int unsigned i = 1; i <= LAT_MAX && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = keypad_pressed;
        end
        check("accept_latency", seen, 1);
    endtask

    task automatic press_long(input int unsigned row, input logic [3:0] mask, input int unsigned hold);
        logic [4:0]  code;
        bit          seen;
        int unsigned n;
        code = key_code(row, mask);
        exp_q.push_back('{code: code, offset: 0});
`ifdef KEYPAD_REPEAT_EN
        for (int unsigned o = RD; o <= hold; o += RP) exp_q.push_back('{code: code, offset: o});
`endif
        @(negedge clk);
        k_row  = 2'(row);
        k_mask = mask;
        k_down = 1'b1;
        wait_accept(seen);
        if (!seen) begin
            k_down = 1'b0;
            exp_q.delete();
            repeat (4 * SCAN + 3 * DB) @(posedge clk);
            return;
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        k_down = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (key_held && n < DB + 12);
        check("release_latency", n, DB + 2);
        check("key_kept_after_release", key, code);
        check("row_after_release", row_n, row_pat(row + 1));
        repeat (4) @(posedge clk);
    endtask

    task automatic bounce(input int unsigned row, input logic [3:0] mask, input int unsigned dur);
        logic [4:0] key_before;
        key_before = key;
        @(negedge clk);
        k_row  = 2'(row);
        k_mask = mask;
        k_down = 1'b1;
        repeat (dur) @(posedge clk);
        @(negedge clk);
        k_down = 1'b0;
        repeat (DB + 4 * SCAN) @(posedge clk);
        #1;
        check("bounce_key_unchanged", key, key_before);
        check("bounce_not_held", key_held, 0);
    endtask

    initial begin : stimulus
        bit          seen;
        logic [4:0]  key_before;
        logic [3:0]  mask;
        #3;
        check("rst_row_n", row_n, 4'b1110);
        check("rst_key", key, 0);
        check("rst_pressed", keypad_pressed, 0);
        check("rst_held", key_held, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check("idle_row_rotation", row_n, row_pat(k / 4));
        end

        // Asynchronous reset while row 1 is driven
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_scan_row", row_n, 4'b1110);
        check("async_rst_scan_held", key_held, 0);
        @(negedge clk);
        rst_n = 1'b1;

        press_long(2, 4'b0010, 40);
        check("press_r2c1_key", key, 5'b01001);

        // Bounce on row 0, aligned to the start of row 0's scan slot
        for (int unsigned i = 0; i < 20 && row_n != 4'b1110; i++) begin
            @(posedge clk);
            #1;
        end
        key_before = key;
        @(negedge clk);
        k_row  = 2'd0;
        k_mask = 4'b1000;
        k_down = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        k_down = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bounce_rescan_row0", row_n, 4'b1110);
        check("bounce_r0c3_key", key, key_before);
        repeat (DB + 4 * SCAN) @(posedge clk);

        press_long(1, 4'b1001, 40);
        check("multi_key", key, 5'b10100);

        press_long(3, 4'b0100, 40);
        check("press_r3c2_key", key, 5'b01110);

        // Asynchronous reset while a key is held
        exp_q.push_back('{code: key_code(1, 4'b0100), offset: 0});
        @(negedge clk);
        k_row  = 2'd1;
        k_mask = 4'b0100;
        k_down = 1'b1;
        wait_accept(seen);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_held_row", row_n, 4'b1110);
        check("async_rst_held_key", key, 0);
        check("async_rst_held_flag", key_held, 0);
        check("async_rst_held_pressed", keypad_pressed, 0);
        k_down = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int unsigned t = 0; t < 20; t++) begin
            if ($urandom_range(0, 2) == 0) mask = 4'($urandom_range(1, 15));
            else mask = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 3) bounce($urandom_range(0, 3), mask, $urandom_range(1, 5));
            else press_long($urandom_range(0, 3), mask, pick_hold());
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end

        repeat (8) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
